wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Clocked writeback stage directly downstream of the asynchronous ALU.
- Detects ALU completion via its level `ready` signal, captures result, instruction word, CPSR image and write flag.
- Commits Rd to the register file and the NZCV flags to the architectural CPSR.
- Hands the ALU its next-operation request by toggling a two-phase trigger line.
- Sole owner of `cpsr_o`, which feeds the decoder and fetch logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `alu_ready_i` synchronizer (legal 2..4).
- CPSR_RESET, 32'h0000_0000, value loaded into `cpsr_o` on reset.

Ports:
- clk  input  1  stage clock.
- reset  input  1  reset, synchronous, active-high.
- alu_ready_i  input  1  ALU result-valid level; asynchronous to clk; drops at op start, rises at op end.
- alu_result_i  input  32  ALU dataOut1.
- alu_instr_i  input  32  instruction word passed through by ALU (dataOut3).
- alu_cpsr_i  input  32  ALU-computed CPSR image; only [31:28] used.
- alu_w_i  input  1  ALU write-enable qualifier (0 for TST/TEQ/CMP/CMN).
- alu_trigger_o  output  1  two-phase request to ALU; each toggle starts one ALU operation.
- rf_we_o  output  1  register-file write strobe, one cycle.
- rf_waddr_o  output  4  destination register, instr[15:12].
- rf_wdata_o  output  32  write data.
- pc_wr_o  output  1  one-cycle pulse when the committed write targets R15; fetch flushes on it.
- cpsr_o  output  32  architectural CPSR.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - alu_trigger_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pc_wr_o=0.
  - cpsr_o=CPSR_RESET, busy_o=1.
  - Synchronizer flops cleared; state=START.
- Synchronizer: `alu_ready_i` passes through SYNC_STAGES flops; a rising edge is detected on the last stage (rdy_s & ~rdy_q).
- FSM states START, IDLE, LATCH, WRITE, TRIG:
  - START: toggle alu_trigger_o once -> IDLE. This gives the ALU its initial request after reset.
  - IDLE: busy_o=0; on detected ready rise -> LATCH. Ready level high without an edge is ignored.
  - LATCH: register alu_result_i, alu_instr_i, alu_cpsr_i[31:28], alu_w_i. The ALU holds these stable while ready is high. -> WRITE.
  - WRITE:
    - rf_we_o = latched w AND instr[27:26]==2'b00; rf_waddr_o=instr[15:12]; rf_wdata_o=result.
    - If instr[20]=1 and instr[27:26]==2'b00: cpsr_o[31:28] <= latched flags; cpsr_o[27:0] unchanged.
    - pc_wr_o = rf_we_o AND instr[15:12]==4'hF.
    - -> TRIG.
  - TRIG: toggle alu_trigger_o -> IDLE.
- rf_we_o and pc_wr_o are high only in the WRITE cycle and are 0 in every other state.
- Non-data-processing types (instr[27:26]!=00): no RF write, no CPSR change; trigger still toggles so the pipeline never stalls.
- Latency: first clk edge seeing the synchronized rise = cycle 0; LATCH at cycle 1, WRITE at cycle 2, trigger toggle at cycle 3.
- Ready falling edges are ignored in all states.
- A ready rise arriving during LATCH/WRITE/TRIG is impossible by protocol: the ALU drops ready only after a trigger toggle. If one is detected anyway, it is discarded; no queuing.
- Reset mid-operation: the synchronous reset wins over any transition. Outputs return to reset values and the FSM restarts at START, so exactly one fresh trigger toggle is issued.

Optional Feature:
- Macro: WB_COND_EN.
- Defined:
  - WRITE evaluates ARM condition instr[31:28] (EQ..AL, 16 codes; NV treated as never) against the pre-update cpsr_o[31:28].
  - On fail: rf_we_o=0, pc_wr_o=0, CPSR unchanged.
  - Adds 1-bit output cond_fail_o, pulsed in the WRITE cycle on fail, 0 otherwise and at reset.
- Undefined: the condition field is ignored, every instruction commits, and cond_fail_o does not exist.

Test Plan:
- Reset then release -> alu_trigger_o goes 0->1 exactly once; cpsr_o=CPSR_RESET; rf_we_o never asserted.
- ADD R3 (instr=32'hE090_3002, result=32'h0000_0005, w=1, cpsr_in=32'h2000_0000), raise ready -> 2+SYNC_STAGES cycles later rf_we_o=1 for one cycle, waddr=3, wdata=5, cpsr_o[31:28]=4'b0010, trigger toggles next cycle.
- CMP (instr=32'hE150_0001, w=0, cpsr_in=32'h6000_0000) -> rf_we_o stays 0; cpsr_o[31:28]=4'b0110.
- MOV PC (instr=32'hE1A0_F000, result=32'h0000_0100, w=1) -> rf_we_o=1, pc_wr_o=1 same cycle, waddr=4'hF.
- Assert reset in the WRITE cycle -> rf_we_o=0 on the following edge; after release one trigger toggle; no CPSR update from the aborted op.
- WB_COND_EN with Z=0, MOVEQ R1 (instr=32'h01A0_1002) -> rf_we_o=0, cond_fail_o=1 one cycle, trigger still toggles.

Source files
------------

// File: rtl/wb_stage_if.sv
// Signal bundle between the asynchronous ALU, the writeback stage and its consumers.
// With WB_COND_EN defined the bundle also carries cond_fail_o.
interface wb_stage_if;
  logic        alu_ready_i;
  logic [31:0] alu_result_i;
  logic [31:0] alu_instr_i;
  logic [31:0] alu_cpsr_i;
  logic        alu_w_i;
  logic        alu_trigger_o;
  logic        rf_we_o;
  logic [3:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        pc_wr_o;
  logic [31:0] cpsr_o;
  logic        busy_o;
`ifdef WB_COND_EN
  logic        cond_fail_o;
`endif

  modport slave (
    input  alu_ready_i, alu_result_i, alu_instr_i, alu_cpsr_i, alu_w_i,
    output alu_trigger_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_wr_o, cpsr_o, busy_o
`ifdef WB_COND_EN
    , output cond_fail_o
`endif
  );

  modport master (
    output alu_ready_i, alu_result_i, alu_instr_i, alu_cpsr_i, alu_w_i,
    input  alu_trigger_o, rf_we_o, rf_waddr_o, rf_wdata_o, pc_wr_o, cpsr_o, busy_o
`ifdef WB_COND_EN
    , input cond_fail_o
`endif
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage behind the asynchronous ALU: commits Rd and NZCV, re-arms the ALU.
// Optional WB_COND_EN adds ARM condition evaluation and the cond_fail_o pulse.
//
// state | meaning
// START | issue the first trigger toggle after reset
// IDLE  | wait for a synchronized ready rise
// LATCH | capture ALU outputs (held stable while ready is high)
// WRITE | drive RF write strobe, update CPSR flags
// TRIG  | toggle trigger to start the next ALU op
module wb_stage #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] CPSR_RESET  = 32'h0000_0000
) (
  input  logic      clk,
  input  logic      reset,
  wb_stage_if.slave bus
);

  typedef enum logic [2:0] {
    START = 3'd0,
    IDLE  = 3'd1,
    LATCH = 3'd2,
    WRITE = 3'd3,
    TRIG  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_q;
  logic                   rdy_s;
  logic                   rise;

  logic        trig_q, trig_d;
  logic [31:0] cpsr_q, cpsr_d;

  logic [31:0] res_q;
  logic [3:0]  rd_q;
  logic [3:0]  flags_q;
  logic        dp_q;
  logic        s_q;
  logic        w_q;
  logic [3:0]  cond_q;

  logic latch_en;
  logic we;
  logic pc_wr;
  logic busy;
  logic cond_ok;
  logic cond_fail;

`ifdef WB_COND_EN
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = cy;
      4'h3:    cond_pass = ~cy;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = cy & ~z;
      4'h9:    cond_pass = ~cy | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = ~z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign cond_ok = cond_pass(cond_q, cpsr_q[31:28]);
`else
  assign cond_ok = 1'b1;
`endif

  assign rdy_s = sync_q[SYNC_STAGES-1];
  assign rise  = rdy_s & ~rdy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START;
      sync_q  <= '0;
      rdy_q   <= 1'b0;
      trig_q  <= 1'b0;
      cpsr_q  <= CPSR_RESET;
      res_q   <= '0;
      rd_q    <= '0;
      flags_q <= '0;
      dp_q    <= 1'b0;
      s_q     <= 1'b0;
      w_q     <= 1'b0;
      cond_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.alu_ready_i};
      rdy_q   <= rdy_s;
      trig_q  <= trig_d;
      cpsr_q  <= cpsr_d;
      if (latch_en) begin
        res_q   <= bus.alu_result_i;
        rd_q    <= bus.alu_instr_i[15:12];
        flags_q <= bus.alu_cpsr_i[31:28];
        dp_q    <= (bus.alu_instr_i[27:26] == 2'b00);
        s_q     <= bus.alu_instr_i[20];
        w_q     <= bus.alu_w_i;
        cond_q  <= bus.alu_instr_i[31:28];
      end
    end
  end

  // Rises seen outside IDLE are consumed by rdy_q and simply dropped.
  always_comb begin
    state_d   = state_q;
    trig_d    = trig_q;
    cpsr_d    = cpsr_q;
    latch_en  = 1'b0;
    we        = 1'b0;
    pc_wr     = 1'b0;
    cond_fail = 1'b0;
    busy      = 1'b1;
    case (state_q)
      START: begin
        trig_d  = ~trig_q;
        state_d = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        if (rise) state_d = LATCH;
      end
      LATCH: begin
        latch_en = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        cond_fail = ~cond_ok;
        we        = w_q & dp_q & cond_ok;
        pc_wr     = we & (rd_q == 4'hF);
        if (s_q && dp_q && cond_ok) cpsr_d = {flags_q, cpsr_q[27:0]};
        state_d = TRIG;
      end
      TRIG: begin
        trig_d  = ~trig_q;
        state_d = IDLE;
      end
      default: state_d = START;
    endcase
  end

  assign bus.alu_trigger_o = trig_q;
  assign bus.rf_we_o       = we;
  assign bus.rf_waddr_o    = rd_q;
  assign bus.rf_wdata_o    = res_q;
  assign bus.pc_wr_o       = pc_wr;
  assign bus.cpsr_o        = cpsr_q;
  assign bus.busy_o        = busy;
`ifdef WB_COND_EN
  assign bus.cond_fail_o   = cond_fail;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed ops, randomized ops against a transaction model, reset cases.
module tb_wb_stage;
  localparam int          SYNC     = 2;
  localparam logic [31:0] CPSR_RST = 32'h0000_01D3;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] m_cpsr;
  logic        m_trig;

  wb_stage_if bus ();

  wb_stage #(.SYNC_STAGES(SYNC), .CPSR_RESET(CPSR_RST)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ARM condition table evaluated on the architectural flags as the model holds them.
  function automatic bit arm_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Run one ALU operation through the stage; every output is checked per cycle against the model.
  task automatic run_op(input logic [31:0] instr, input logic [31:0] result,
                        input logic [31:0] cpsr_in, input logic w, input string tag);
    bit          pass, dp, exp_we, exp_pc, exp_cf;
    logic [31:0] exp_cpsr;
    pass     = 1'b1;
`ifdef WB_COND_EN
    pass     = arm_cond(instr[31:28], m_cpsr[31:28]);
`endif
    dp       = (instr[27:26] == 2'b00);
    exp_we   = w && dp && pass;
    exp_pc   = exp_we && (instr[15:12] == 4'hF);
    exp_cf   = !pass;
    exp_cpsr = (dp && instr[20] && pass) ? {cpsr_in[31:28], m_cpsr[27:0]} : m_cpsr;

    @(negedge clk);
    bus.alu_instr_i  = instr;
    bus.alu_result_i = result;
    bus.alu_cpsr_i   = cpsr_in;
    bus.alu_w_i      = w;
    bus.alu_ready_i  = 1'b1;
    for (int n = 1; n <= SYNC + 5; n++) begin
      @(negedge clk);
      total++;
      if (bus.rf_we_o !== ((n == SYNC + 2) ? exp_we : 1'b0)) begin
        bad++;
        $display("FAIL %s rf_we cyc%0d: got %b want %b", tag, n, bus.rf_we_o, (n == SYNC + 2) ? exp_we : 1'b0);
      end
      total++;
      if (bus.pc_wr_o !== ((n == SYNC + 2) ? exp_pc : 1'b0)) begin
        bad++;
        $display("FAIL %s pc_wr cyc%0d: got %b want %b", tag, n, bus.pc_wr_o, (n == SYNC + 2) ? exp_pc : 1'b0);
      end
`ifdef WB_COND_EN
      total++;
      if (bus.cond_fail_o !== ((n == SYNC + 2) ? exp_cf : 1'b0)) begin
        bad++;
        $display("FAIL %s cond_fail cyc%0d: got %b want %b", tag, n, bus.cond_fail_o, (n == SYNC + 2) ? exp_cf : 1'b0);
      end
`endif
      if (n == SYNC + 2) begin
        total++;
        if (bus.rf_waddr_o !== instr[15:12]) begin
          bad++;
          $display("FAIL %s waddr: got %h want %h", tag, bus.rf_waddr_o, instr[15:12]);
        end
        total++;
        if (bus.rf_wdata_o !== result) begin
          bad++;
          $display("FAIL %s wdata: got %h want %h", tag, bus.rf_wdata_o, result);
        end
        total++;
        if (bus.busy_o !== 1'b1) begin
          bad++;
          $display("FAIL %s busy in write: got %b want 1", tag, bus.busy_o);
        end
      end
      if (n == SYNC + 3 || n == SYNC + 4) begin
        total++;
        if (bus.alu_trigger_o !== ((n == SYNC + 4) ? ~m_trig : m_trig)) begin
          bad++;
          $display("FAIL %s trigger cyc%0d: got %b want %b", tag, n, bus.alu_trigger_o, (n == SYNC + 4) ? ~m_trig : m_trig);
        end
        total++;
        if (bus.cpsr_o !== exp_cpsr) begin
          bad++;
          $display("FAIL %s cpsr cyc%0d: got %h want %h", tag, n, bus.cpsr_o, exp_cpsr);
        end
      end
      if (n == SYNC + 5) begin
        total++;
        if (bus.busy_o !== 1'b0) begin
          bad++;
          $display("FAIL %s busy after op: got %b want 0", tag, bus.busy_o);
        end
      end
    end
    m_trig = ~m_trig;
    m_cpsr = exp_cpsr;
    bus.alu_ready_i = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  // After reset release exactly one trigger toggle must appear and no write.
  task automatic release_check(input string tag);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s busy after start: got %b want 0", tag, bus.busy_o);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (bus.alu_trigger_o !== 1'b1 || bus.rf_we_o !== 1'b0) begin
        bad++;
        $display("FAIL %s start toggle cyc%0d: trig=%b we=%b want trig=1 we=0", tag, i, bus.alu_trigger_o, bus.rf_we_o);
      end
      @(negedge clk);
    end
    m_trig = 1'b1;
    m_cpsr = CPSR_RST;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.alu_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.alu_trigger_o !== 1'b0 || bus.rf_we_o !== 1'b0 || bus.pc_wr_o !== 1'b0) begin
      bad++;
      $display("FAIL reset strobes: trig=%b we=%b pc=%b want 0", bus.alu_trigger_o, bus.rf_we_o, bus.pc_wr_o);
    end
    total++;
    if (bus.rf_waddr_o !== 4'h0 || bus.rf_wdata_o !== 32'h0) begin
      bad++;
      $display("FAIL reset rf bus: waddr=%h wdata=%h want 0", bus.rf_waddr_o, bus.rf_wdata_o);
    end
    total++;
    if (bus.cpsr_o !== CPSR_RST) begin
      bad++;
      $display("FAIL reset cpsr: got %h want %h", bus.cpsr_o, CPSR_RST);
    end
    total++;
    if (bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL reset busy: got %b want 1", bus.busy_o);
    end
    release_check("reset");
  endtask

  task automatic test_directed();
    run_op(32'hE090_3002, 32'h0000_0005, 32'h2000_0000, 1'b1, "add_r3");
    run_op(32'hE150_0001, 32'h0000_0000, 32'h6000_0000, 1'b0, "cmp");
    run_op(32'hE1A0_F000, 32'h0000_0100, 32'h9000_0000, 1'b1, "mov_pc");
    run_op(32'hE590_2000, 32'hDEAD_BEEF, 32'hF000_0000, 1'b1, "ldr_nodp");
  endtask

  task automatic test_level_hold();
    logic t0;
    run_op(32'hE080_4005, 32'h0000_1234, 32'h0000_0000, 1'b1, "pre_hold");
    t0 = bus.alu_trigger_o;
    @(negedge clk);
    bus.alu_ready_i = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    bus.alu_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    bus.alu_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    // rise after a fall does start an op; the stale level before did too, so just check idle afterwards
    bus.alu_ready_i = 1'b0;
    repeat (SYNC + 8) @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0 || bus.rf_we_o !== 1'b0) begin
      bad++;
      $display("FAIL level_hold idle: busy=%b we=%b want 0 0", bus.busy_o, bus.rf_we_o);
    end
    total++;
    if (bus.alu_trigger_o !== t0) begin
      bad++;
      $display("FAIL level_hold trigger: got %b want %b (two ops = even toggles)", bus.alu_trigger_o, t0);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int k = 0; k < 24; k++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[27:26] = 2'b00;
      run_op(ins, $urandom, $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_in_write();
    @(negedge clk);
    bus.alu_instr_i  = 32'hE090_5002;
    bus.alu_result_i = 32'h0000_0077;
    bus.alu_cpsr_i   = 32'hF000_0000;
    bus.alu_w_i      = 1'b1;
    bus.alu_ready_i  = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    total++;
    if (bus.rf_we_o !== 1'b1) begin
      bad++;
      $display("FAIL abort reach write: rf_we got %b want 1", bus.rf_we_o);
    end
    reset = 1'b1;
    bus.alu_ready_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rf_we_o !== 1'b0 || bus.alu_trigger_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      bad++;
      $display("FAIL abort outputs: we=%b trig=%b busy=%b want 0 0 1", bus.rf_we_o, bus.alu_trigger_o, bus.busy_o);
    end
    total++;
    if (bus.cpsr_o !== CPSR_RST) begin
      bad++;
      $display("FAIL abort cpsr: got %h want %h", bus.cpsr_o, CPSR_RST);
    end
    repeat (2) @(negedge clk);
    release_check("abort");
    total++;
    if (bus.cpsr_o !== CPSR_RST) begin
      bad++;
      $display("FAIL abort cpsr after release: got %h want %h", bus.cpsr_o, CPSR_RST);
    end
  endtask

`ifdef WB_COND_EN
  task automatic test_cond();
    run_op(32'hE090_3002, 32'h0000_0005, 32'h2000_0000, 1'b1, "cond_setup");
    run_op(32'h01A0_1002, 32'h0000_0009, 32'h4000_0000, 1'b1, "moveq_fail");
    run_op(32'hF1A0_1002, 32'h0000_0009, 32'h4000_0000, 1'b1, "nv_fail");
    run_op(32'h1090_2002, 32'h0000_0003, 32'h4000_0000, 1'b1, "addsne_pass");
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    m_cpsr = CPSR_RST;
    m_trig = 1'b0;
    reset = 1'b1;
    bus.alu_ready_i  = 1'b0;
    bus.alu_result_i = '0;
    bus.alu_instr_i  = '0;
    bus.alu_cpsr_i   = '0;
    bus.alu_w_i      = 1'b0;
    test_reset();
    test_directed();
`ifdef WB_COND_EN
    test_cond();
`endif
    test_level_hold();
    test_random();
    test_reset_in_write();
    run_op(32'hE090_3002, 32'h0000_0005, 32'h2000_0000, 1'b1, "post_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
